// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: in-order pipeline writes win, long-latency results queue in a squashable FIFO.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we_i,
    input  logic [AW-1:0]              pipe_waddr_i,
    input  logic [DW-1:0]              pipe_wdata_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [AW-1:0]              lsu_waddr_i,
    input  logic [DW-1:0]              lsu_wdata_i,
    output logic                       we_o,
    output logic [AW-1:0]              waddr_o,
    output logic [DW-1:0]              wdata_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     q_count_o
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_cfg
        $error("wb_arbiter: illegal DEPTH or STARVE_MAX");
    end

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW:0]      rd_q, rd_d, wr_q, wr_d;

    logic [PW:0]      occ;
    logic [PW-1:0]    rd_idx, wr_idx;
    logic             not_empty, head_vld, push, pop;

    assign rd_idx    = rd_q[PW-1:0];
    assign wr_idx    = wr_q[PW-1:0];
    assign occ       = wr_q - rd_q;
    assign not_empty = (occ != '0);
    assign head_vld  = rst && not_empty && vld_q[rd_idx];

    assign lsu_ready_o = rst && (occ < (PW+1)'(DEPTH));
    assign q_count_o   = rst ? occ : '0;

    // Squashed heads never need the write port, so they drain even under pipeline priority.
    assign pop  = rst && not_empty && (!vld_q[rd_idx] || !pipe_we_i);
    assign push = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != '0)
               && !(pipe_we_i && (pipe_waddr_i == lsu_waddr_i));

    always_comb begin
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        if (pipe_we_i) begin
            we_o    = 1'b1;
            waddr_o = pipe_waddr_i;
            wdata_o = pipe_wdata_i;
        end else if (head_vld) begin
            we_o    = 1'b1;
            waddr_o = addr_q[rd_idx];
            wdata_o = data_q[rd_idx];
        end
    end

    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (pipe_we_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == pipe_waddr_i) vld_d[i] = 1'b0;
            end
        end
        if (pop) rd_d = rd_q + 1'b1;
        if (push) begin
            vld_d[wr_idx] = 1'b1;
            wr_d          = wr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_idx] <= lsu_waddr_i;
            data_q[wr_idx] <= lsu_wdata_i;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (head_vld && pipe_we_i && (starve_q < SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d >= SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_o = stall_q;
`else
    assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue model.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipe_we_i = 1'b0;
    logic [AW-1:0] pipe_waddr_i = '0;
    logic [DW-1:0] pipe_wdata_i = '0;
    logic          lsu_valid_i = 1'b0;
    logic          lsu_ready_o;
    logic [AW-1:0] lsu_waddr_i = '0;
    logic [DW-1:0] lsu_wdata_i = '0;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic          stall_o;
    logic [$clog2(DEPTH):0] q_count_o;

    wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .stall_o(stall_o), .q_count_o(q_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            v;
    } ent_t;

    ent_t q[$];
    int   starve = 0;
    bit   stall_exp = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic cyc(input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit rn);
        bit            e_we, e_rdy, blocked, popped;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        int            e_cnt;
        @(negedge clk);
        rst = rn; pipe_we_i = pw; pipe_waddr_i = pa; pipe_wdata_i = pd;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
        #1;
        e_rdy = rn && (q.size() < DEPTH);
        e_cnt = rn ? q.size() : 0;
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (pw) begin
            e_we = 1'b1; e_a = pa; e_d = pd;
        end else if (rn && q.size() > 0 && q[0].v) begin
            e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
        end
        chk("we", 32'(we_o), 32'(e_we));
        chk("ready", 32'(lsu_ready_o), 32'(e_rdy));
        chk("count", 32'(q_count_o), 32'(e_cnt));
        chk("stall", 32'(stall_o), 32'(stall_exp));
        if (e_we) begin
            chk("waddr", 32'(waddr_o), 32'(e_a));
            chk("wdata", wdata_o, e_d);
        end
        @(posedge clk);
        if (!rn) begin
            q.delete();
            starve = 0;
            stall_exp = 1'b0;
        end else begin
            popped = 1'b0; blocked = 1'b0;
            if (q.size() > 0) begin
                if (!q[0].v || !pw) begin
                    void'(q.pop_front());
                    popped = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
            if (pw) foreach (q[i]) if (q[i].a == pa) q[i].v = 1'b0;
            if (lv && e_rdy && la != '0 && !(pw && la == pa)) q.push_back('{a: la, d: ld, v: 1'b1});
`ifdef WB_STARVE_GUARD_EN
            if (popped) starve = 0;
            else if (blocked && starve < STARVE_MAX) starve++;
            stall_exp = (starve >= STARVE_MAX);
`else
            stall_exp = 1'b0;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 1);
    endtask

    initial begin
        // Reset with the pipeline writing, so we_o must follow pipe_we_i alone.
        cyc(1, 5'd9, 32'h1234, 1, 5'd3, 32'h55, 0);
        cyc(0, '0, '0, 0, '0, '0, 0);
        idle(1);

        // Single LSU result with idle pipeline appears one cycle later.
        cyc(0, '0, '0, 1, 5'd5, 32'hDEADBEEF, 1);
        idle(2);

        // Fill the queue behind pipeline traffic, hold a fifth request, then drain in order.
        for (int i = 1; i <= 4; i++) cyc(1, 5'd20, 32'hA000 + i, 1, 5'(i), 32'h100 + i, 1);
        cyc(1, 5'd20, 32'hA005, 1, 5'd9, 32'h999, 1);
        cyc(0, '0, '0, 1, 5'd9, 32'h999, 1);
        cyc(0, '0, '0, 1, 5'd9, 32'h999, 1);
        idle(6);

        // Pipeline write squashes a queued entry to the same register.
        cyc(1, 5'd20, 32'hB0, 1, 5'd7, 32'h11, 1);
        cyc(1, 5'd7, 32'h22, 0, '0, '0, 1);
        idle(3);
        // Same-cycle collision: LSU result is dropped.
        cyc(1, 5'd6, 32'h66, 1, 5'd6, 32'h77, 1);
        idle(2);

        // Head held off by the pipeline long enough to trip the starvation guard.
        cyc(1, 5'd20, 32'hC0, 1, 5'd3, 32'h33, 1);
        for (int i = 0; i < STARVE_MAX + 1; i++) cyc(1, 5'd21, 32'hC1 + i, 0, '0, '0, 1);
        idle(3);

        // Result to x0 is discarded.
        cyc(0, '0, '0, 1, 5'd0, 32'hFFFF, 1);
        idle(2);

        // Reset mid-operation drops queued results.
        for (int i = 1; i <= 3; i++) cyc(1, 5'd20, 32'hD0, 1, 5'(10 + i), 32'hD00 + i, 1);
        cyc(1, 5'd12, 32'hE0, 0, '0, '0, 0);
        idle(3);

        // Random traffic over a small address range to provoke squashes and collisions.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) >= 1);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of every write-back value.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DEPTH, default 4, long-latency queue entries, power of two, 2..16.
REQ-004 Parameter STARVE_MAX, default 8, queue-head wait cycles before stall_o is raised.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 pipe_we_i  in  1  in-order pipeline write request; always accepted, no backpressure.
REQ-008 pipe_waddr_i  in  AW  pipeline destination register.
REQ-009 pipe_wdata_i  in  DW  pipeline write data.
REQ-010 lsu_valid_i  in  1  long-latency (load/div) result valid.
REQ-011 lsu_ready_o  out  1  queue can accept a result this cycle.
REQ-012 lsu_waddr_i  in  AW  long-latency destination register.
REQ-013 lsu_wdata_i  in  DW  long-latency result data.
REQ-014 we_o  out  1  register-file write enable.
REQ-015 waddr_o  out  AW  register-file write address.
REQ-016 wdata_o  out  DW  register-file write data.
REQ-017 stall_o  out  1  registered request for the pipeline to hold pipe_we_i low.
REQ-018 q_count_o  out  log2(DEPTH)+1  current queue occupancy.

Function
REQ-019 An LSU transfer occurs on a cycle where lsu_valid_i and lsu_ready_o are both high; the entry is pushed into a FIFO of DEPTH entries.
REQ-020 lsu_ready_o equals (occupancy < DEPTH), combinational from registered state only; never depends on lsu_valid_i.
REQ-021 Output mux is combinational: pipe_we_i high drives we_o/waddr_o/wdata_o from pipe_*; otherwise a valid queue head drives them and is popped that cycle.
REQ-022 Pipeline has absolute priority; the queue head waits while pipe_we_i is high.
REQ-023 Minimum LSU latency: accepted at cycle N, earliest write on we_o at cycle N+1.
REQ-024 LSU entries with waddr 0 are accepted and discarded without occupying the queue or asserting we_o.
REQ-025 Pipeline writes to address 0 pass through unchanged; x0 protection stays in the register file.
REQ-026 Ordering rule: a pipeline write to address A squashes (invalidates) every queued entry with address A in the same cycle.
REQ-027 A simultaneous LSU transfer to the same address A as a pipeline write is accepted and dropped, not enqueued.
REQ-028 Squashed entries are skipped at the head without asserting we_o; they free their slot when popped.
REQ-029 Simultaneous push and pop with a full queue is allowed only when the pop frees a slot earlier in the same cycle; lsu_ready_o is not raised combinationally, so a full queue accepts again only on the following cycle.
REQ-030 Read and write pointers wrap modulo DEPTH; occupancy is tracked with one extra bit to distinguish full from empty.
REQ-031 we_o is low whenever pipe_we_i is low and the queue has no valid head.

Reset
REQ-032 While rst is low at a rising edge: queue empty, all entry valid bits 0, pointers 0, starve counter 0, stall_o 0.
REQ-033 During reset, lsu_ready_o is 0, we_o follows pipe_we_i only, and q_count_o is 0.
REQ-034 Reset mid-operation discards all queued entries; no queued write reaches we_o afterwards.

Configuration
REQ-035 Macro WB_STARVE_GUARD_EN defined: the counter increments each cycle a valid head is blocked by pipe_we_i and clears on pop; reaching STARVE_MAX sets stall_o on the next cycle, and stall_o clears the cycle after the head pops.
REQ-036 WB_STARVE_GUARD_EN undefined: no counter; stall_o is tied to 0.

Verification
REQ-037 LSU push addr 5, data 0xDEADBEEF, pipe idle -> cycle N+1: we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; q_count_o returns to 0.
REQ-038 Push 4 entries (addr 1..4) with pipe_we_i held high -> lsu_ready_o=0 after the 4th; fifth valid held; release pipe -> writes 1,2,3,4 in order, then the fifth.
REQ-039 Queue holds addr 7=0x11; pipe writes addr 7=0x22 -> entry squashed; only 0x22 is written; no later write to 7.
REQ-040 With the guard enabled, STARVE_MAX=8, one entry queued and pipe_we_i high for 8 cycles -> stall_o=1 on cycle 9; pipe drops -> entry written, stall_o=0 next cycle.
REQ-041 LSU push to addr 0 -> accepted, q_count_o stays 0, we_o never asserted.
REQ-042 Fill 3 entries, assert rst low one cycle -> q_count_o=0, no queued writes thereafter, lsu_ready_o=1 after reset.
